// File: rtl/fpu_operand_unit_pkg.sv
// Shared sizes, forward-select encodings and the operand-source selection helper
// for the FPU operand unit.
package fpu_operand_unit_pkg;

  localparam int unsigned NumRegs   = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned AddrWidth = $clog2(NumRegs);

  typedef enum logic [1:0] {
    FwdReg = 2'd0,
    FwdEd  = 2'd1,
    FwdWd  = 2'd2
  } fwd_sel_e;

  // E3 is younger than writeback, so it wins when both target the same register.
  function automatic fwd_sel_e fwd_select(input logic [AddrWidth-1:0] src,
                                          input logic                 e3w,
                                          input logic [AddrWidth-1:0] e3n,
                                          input logic                 ww,
                                          input logic [AddrWidth-1:0] wn);
    if (e3w && (e3n == src)) begin
      return FwdEd;
    end else if (ww && (wn == src)) begin
      return FwdWd;
    end
    return FwdReg;
  endfunction

endpackage

// File: rtl/fpu_regfile.sv
// 32 x 32-bit FP register file: three asynchronous read ports with write-through,
// one synchronous write port, asynchronous active-low clear.
module fpu_regfile
  import fpu_operand_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [AddrWidth-1:0] ra,
  input  logic [AddrWidth-1:0] rb,
  input  logic [AddrWidth-1:0] rc,
  output logic [DataWidth-1:0] qa,
  output logic [DataWidth-1:0] qb,
  output logic [DataWidth-1:0] qc,
  input  logic [AddrWidth-1:0] wn,
  input  logic                 we,
  input  logic [DataWidth-1:0] wd
);

  logic [DataWidth-1:0] regs_q [NumRegs];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[wn] <= wd;
    end
  end

  // Bypass stays combinational so it also applies while clrn is low.
  always_comb begin
    qa = (we && (wn == ra)) ? wd : regs_q[ra];
    qb = (we && (wn == rb)) ? wd : regs_q[rb];
    qc = (we && (wn == rc)) ? wd : regs_q[rc];
  end

endmodule

// File: rtl/fpu_operand_unit.sv
// FPU operand unit: FP register file, E3/writeback operand forwarding,
// E1/E2 load-use and divider stall detection, and a saturating stall counter.
module fpu_operand_unit
  import fpu_operand_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [AddrWidth-1:0] fs,
  input  logic [AddrWidth-1:0] ft,
  input  logic                 use_fs,
  input  logic                 use_ft,
  input  logic [AddrWidth-1:0] e1n,
  input  logic [AddrWidth-1:0] e2n,
  input  logic [AddrWidth-1:0] e3n,
  input  logic                 e1w,
  input  logic                 e2w,
  input  logic                 e3w,
  input  logic [DataWidth-1:0] ed,
  input  logic [AddrWidth-1:0] wn,
  input  logic                 ww,
  input  logic [DataWidth-1:0] wd,
  input  logic                 st_ds,
  input  logic [AddrWidth-1:0] rn,
  output logic [DataWidth-1:0] a,
  output logic [DataWidth-1:0] b,
  output logic [DataWidth-1:0] rq,
  output logic [1:0]           fwda,
  output logic [1:0]           fwdb,
  output logic                 stall_fp,
  output logic [15:0]          stall_cnt
);

  logic [DataWidth-1:0] qa, qb;
  fwd_sel_e             sel_a, sel_b;
  logic                 haz_fs, haz_ft;
  logic [15:0]          stall_cnt_q, stall_cnt_d;

  fpu_regfile u_regfile (
    .clk  (clk),
    .clrn (clrn),
    .ra   (fs),
    .rb   (ft),
    .rc   (rn),
    .qa   (qa),
    .qb   (qb),
    .qc   (rq),
    .wn   (wn),
    .we   (ww),
    .wd   (wd)
  );

  always_comb begin
    sel_a = fwd_select(fs, e3w, e3n, ww, wn);
    sel_b = fwd_select(ft, e3w, e3n, ww, wn);
    fwda  = sel_a;
    fwdb  = sel_b;

    unique case (sel_a)
      FwdEd:   a = ed;
      FwdWd:   a = wd;
      default: a = qa;
    endcase

    unique case (sel_b)
      FwdEd:   b = ed;
      FwdWd:   b = wd;
      default: b = qb;
    endcase
  end

  // E1/E2 results are not yet available for forwarding, so a consumer must wait.
  always_comb begin
    haz_fs   = use_fs && ((e1w && (e1n == fs)) || (e2w && (e2n == fs)));
    haz_ft   = use_ft && ((e1w && (e1n == ft)) || (e2w && (e2n == ft)));
    stall_fp = haz_fs || haz_ft || st_ds;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_fp && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fpu_operand_unit.sv
// Self-checking bench for fpu_operand_unit: directed vector table for forwarding and
// stall decode, plus hand-written sequences for reset, write timing and the stall counter.
module tb_fpu_operand_unit;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  fs, ft, e1n, e2n, e3n, wn, rn;
  logic        use_fs, use_ft, e1w, e2w, e3w, ww, st_ds;
  logic [31:0] ed, wd;
  logic [31:0] a, b, rq;
  logic [1:0]  fwda, fwdb;
  logic        stall_fp;
  logic [15:0] stall_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fpu_operand_unit dut (
    .clk       (clk),
    .clrn      (clrn),
    .fs        (fs),
    .ft        (ft),
    .use_fs    (use_fs),
    .use_ft    (use_ft),
    .e1n       (e1n),
    .e2n       (e2n),
    .e3n       (e3n),
    .e1w       (e1w),
    .e2w       (e2w),
    .e3w       (e3w),
    .ed        (ed),
    .wn        (wn),
    .ww        (ww),
    .wd        (wd),
    .st_ds     (st_ds),
    .rn        (rn),
    .a         (a),
    .b         (b),
    .rq        (rq),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .stall_fp  (stall_fp),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic [4:0]  fs, ft;
    logic        use_fs, use_ft;
    logic [4:0]  e1n;
    logic        e1w;
    logic [4:0]  e2n;
    logic        e2w;
    logic [4:0]  e3n;
    logic        e3w;
    logic [31:0] ed;
    logic [4:0]  wn;
    logic        ww;
    logic [31:0] wd;
    logic [4:0]  rn;
    logic        st_ds;
    logic [31:0] exp_a, exp_b, exp_rq;
    logic [1:0]  exp_fwda, exp_fwdb;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic idle();
    fs = 5'd0; ft = 5'd0; use_fs = 1'b0; use_ft = 1'b0;
    e1n = 5'd0; e2n = 5'd0; e3n = 5'd0; e1w = 1'b0; e2w = 1'b0; e3w = 1'b0;
    ed = 32'h0; wn = 5'd0; ww = 1'b0; wd = 32'h0; st_ds = 1'b0; rn = 5'd0;
  endtask

  task automatic write_reg(input logic [4:0] n, input logic [31:0] d);
    @(negedge clk);
    wn = n; wd = d; ww = 1'b1;
    @(negedge clk);
    ww = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    fs = v.fs; ft = v.ft; use_fs = v.use_fs; use_ft = v.use_ft;
    e1n = v.e1n; e1w = v.e1w; e2n = v.e2n; e2w = v.e2w; e3n = v.e3n; e3w = v.e3w;
    ed = v.ed; wn = v.wn; ww = v.ww; wd = v.wd; rn = v.rn; st_ds = v.st_ds;
  endtask

  initial begin
    // Field order: fs ft use_fs use_ft e1n e1w e2n e2w e3n e3w ed wn ww wd rn st_ds
    //              exp_a exp_b exp_rq exp_fwda exp_fwdb exp_stall
    vecs[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,
                 5'd0, 1'b0, 32'h0, 5'd8, 1'b0,
                 32'h11111111, 32'h22222222, 32'hDEADBEEF, 2'd0, 2'd0, 1'b0};
    vecs[1]  = '{5'd7, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,
                 5'd7, 1'b1, 32'h40000000, 5'd7, 1'b0,
                 32'h40000000, 32'h11111111, 32'h40000000, 2'd2, 2'd0, 1'b0};
    vecs[2]  = '{5'd3, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,
                 5'd0, 1'b0, 32'h0, 5'd0, 1'b0,
                 32'h33333333, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'd0, 2'd0, 1'b1};
    vecs[3]  = '{5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,
                 5'd0, 1'b0, 32'h0, 5'd0, 1'b0,
                 32'h33333333, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'd0, 2'd0, 1'b0};
    vecs[4]  = '{5'd4, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 32'hC0400000,
                 5'd4, 1'b1, 32'h00000001, 5'd4, 1'b0,
                 32'hC0400000, 32'hC0400000, 32'h00000001, 2'd1, 2'd1, 1'b0};
    vecs[5]  = '{5'd1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 32'h0,
                 5'd0, 1'b0, 32'h0, 5'd1, 1'b0,
                 32'h11111111, 32'h00000000, 32'h11111111, 2'd0, 2'd0, 1'b1};
    vecs[6]  = '{5'd2, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 32'h0,
                 5'd0, 1'b0, 32'h0, 5'd2, 1'b0,
                 32'h22222222, 32'h00000000, 32'h22222222, 2'd0, 2'd0, 1'b0};
    vecs[7]  = '{5'd5, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,
                 5'd0, 1'b0, 32'h0, 5'd5, 1'b1,
                 32'h3F800000, 32'h11111111, 32'h3F800000, 2'd0, 2'd0, 1'b1};
    vecs[8]  = '{5'd2, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 32'h12345678,
                 5'd3, 1'b1, 32'hCAFEF00D, 5'd2, 1'b0,
                 32'h12345678, 32'hCAFEF00D, 32'h22222222, 2'd1, 2'd2, 1'b0};
    vecs[9]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 32'h0FFFFFFF,
                 5'd0, 1'b0, 32'h0, 5'd1, 1'b0,
                 32'h11111111, 32'h22222222, 32'h11111111, 2'd0, 2'd0, 1'b1};
    vecs[10] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,
                 5'd0, 1'b1, 32'h0F0F0F0F, 5'd0, 1'b0,
                 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 2'd2, 2'd2, 1'b0};
    vecs[11] = '{5'd8, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 32'h55AA55AA,
                 5'd0, 1'b0, 32'h0, 5'd3, 1'b0,
                 32'h55AA55AA, 32'h11111111, 32'h33333333, 2'd1, 2'd0, 1'b1};

    idle();
    clrn = 1'b0;
    fs = 5'd1; ft = 5'd2; rn = 5'd3;
    #12;
    check("reset_a", a, 32'h0);
    check("reset_rq", rq, 32'h0);
    check("reset_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    @(negedge clk);
    clrn = 1'b1;

    // Divider stall held across exactly 20 rising edges.
    @(negedge clk);
    st_ds = 1'b1;
    repeat (20) @(negedge clk);
    st_ds = 1'b0;
    #1;
    check("stall_cnt_20", {16'h0, stall_cnt}, 32'd20);

    write_reg(5'd0, 32'hA5A5A5A5);
    write_reg(5'd1, 32'h11111111);
    write_reg(5'd2, 32'h22222222);
    write_reg(5'd3, 32'h33333333);
    write_reg(5'd4, 32'h44444444);
    write_reg(5'd8, 32'hDEADBEEF);

    // Write r5, read it from the array on the following cycle.
    @(negedge clk);
    wn = 5'd5; wd = 32'h3F800000; ww = 1'b1;
    @(negedge clk);
    ww = 1'b0; wd = 32'h0; fs = 5'd5; use_fs = 1'b1;
    #1;
    check("wr_then_read_a", a, 32'h3F800000);
    check("wr_then_read_fwda", {30'h0, fwda}, 32'd0);
    idle();

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("v%0d_a", i), a, vecs[i].exp_a);
      check($sformatf("v%0d_b", i), b, vecs[i].exp_b);
      check($sformatf("v%0d_rq", i), rq, vecs[i].exp_rq);
      check($sformatf("v%0d_fwda", i), {30'h0, fwda}, {30'h0, vecs[i].exp_fwda});
      check($sformatf("v%0d_fwdb", i), {30'h0, fwdb}, {30'h0, vecs[i].exp_fwdb});
      check($sformatf("v%0d_stall", i), {31'h0, stall_fp}, {31'h0, vecs[i].exp_stall});
      idle();
    end

    // Table vectors are cleared before each rising edge, so nothing was written or counted.
    #1;
    check("stall_cnt_after_table", {16'h0, stall_cnt}, 32'd20);
    fs = 5'd7; rn = 5'd4;
    #1;
    check("no_write_r7", a, 32'h0);
    check("no_write_r4", rq, 32'h44444444);
    idle();

    // Stall again, then pulse reset mid-run.
    @(negedge clk);
    st_ds = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("stall_cnt_25", {16'h0, stall_cnt}, 32'd25);
    clrn = 1'b0;
    #1;
    check("pulse_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    check("pulse_stall_fp", {31'h0, stall_fp}, 32'd1);
    st_ds = 1'b0;
    for (int r = 0; r < 32; r++) begin
      fs = r[4:0]; rn = r[4:0];
      #1;
      check($sformatf("clr_r%0d", r), a, 32'h0);
    end

    // Write-through visible during reset, but the array write is dropped.
    @(negedge clk);
    wn = 5'd10; wd = 32'h77777777; ww = 1'b1; fs = 5'd10; ft = 5'd1;
    #1;
    check("rst_wt_a", a, 32'h77777777);
    check("rst_wt_fwda", {30'h0, fwda}, 32'd2);
    check("rst_wt_b", b, 32'h0);
    @(negedge clk);
    ww = 1'b0;
    #1;
    check("rst_write_ignored", a, 32'h0);
    clrn = 1'b1;

    write_reg(5'd9, 32'hBADC0FFE);
    fs = 5'd9; rn = 5'd9;
    #1;
    check("post_reset_write_a", a, 32'hBADC0FFE);
    check("post_reset_write_rq", rq, 32'hBADC0FFE);
    check("post_reset_stall_cnt", {16'h0, stall_cnt}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
